// File: rtl/serial_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_deser
// Purpose  : Frames a start-marked serial bit stream into WIDTH-bit words and
//            presents them on a valid/ready port with a one-word buffer.
//            Optional even-parity bit per word: SERIAL_DESER_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             D,
    input  logic             bit_valid,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun
`ifdef SERIAL_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_pos = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_one      = WIDTH'(1);

`ifdef SERIAL_DESER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_shift;

    logic                 w_restart;
    logic                 w_take;
    logic                 w_last;
    logic                 w_complete;
    logic [c_cnt_w-1:0]   w_pos;
    logic [WIDTH-1:0]     w_mask;
    logic [WIDTH-1:0]     w_word;
    logic [WIDTH-1:0]     w_done_word;
`ifdef SERIAL_DESER_PARITY_EN
    logic                 w_par_edge;
    logic                 w_par_bad;
`endif

    // One-hot mask selecting where the bit at stream position w_pos lands.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_mask = (c_one << (WIDTH - 1)) >> w_pos;
        end else begin : g_lsb_first
            assign w_mask = c_one << w_pos;
        end
    endgenerate

    always_comb begin
        w_restart = bit_valid && start;
        w_pos     = w_restart ? '0 : r_count;
        w_take    = bit_valid && (start || (r_state == SHIFT));
        // A restart discards whatever partial word was being collected.
        w_word    = ((w_restart ? '0 : r_shift) & ~w_mask) | ({WIDTH{D}} & w_mask);
        w_last    = (w_pos == c_last_pos);
`ifdef SERIAL_DESER_PARITY_EN
        w_par_edge  = bit_valid && !start && (r_state == PARITY);
        w_par_bad   = ^{r_shift, D};
        w_complete  = w_par_edge;
        w_done_word = r_shift;
`else
        w_complete  = w_take && w_last;
        w_done_word = w_word;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (w_take) begin
                r_shift <= w_word;
                if (w_last) begin
`ifdef SERIAL_DESER_PARITY_EN
                    r_state <= PARITY;
                    r_count <= c_cnt_w'(WIDTH);
                    busy    <= 1'b1;
`else
                    r_state <= IDLE;
                    r_count <= '0;
                    busy    <= 1'b0;
`endif
                end else begin
                    r_state <= SHIFT;
                    r_count <= w_pos + c_cnt_w'(1);
                    busy    <= 1'b1;
                end
            end
`ifdef SERIAL_DESER_PARITY_EN
            else if (w_par_edge) begin
                r_state    <= IDLE;
                r_count    <= '0;
                busy       <= 1'b0;
                parity_err <= w_par_bad;
            end
`endif

            // A word consumed on the completing edge frees the buffer for the new one.
            if (w_complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= w_done_word;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Downstream consumer of the master-slave D flip-flop output.
- Collects the registered serial bit stream (the flip-flop's Q) into WIDTH-bit parallel words.
- Frames words with a start marker and presents each completed word on a valid/ready output handshake with a one-word holding buffer.
- Provides the first word-level stage after the bit-level storage cell.

Parameters:
- WIDTH, 8, data bits per word (2..32).
- MSB_FIRST, 0: 0 = first received bit lands in data_out[0]; 1 = first received bit lands in data_out[WIDTH-1].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  1  serial data bit, driven from the upstream flip-flop Q.
- bit_valid  input  1  D is sampled only when high.
- start  input  1  qualified by bit_valid; marks D as bit 0 of a new word.
- data_out  output  WIDTH  completed word, stable while data_valid=1.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word when data_valid && data_ready.
- busy  output  1  frame in progress (state SHIFT or PARITY).
- overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, bit count=0, shift register=0.
  - data_out=0, data_valid=0, busy=0, overrun=0.
  - Release is synchronous to clk; the first sample is taken on the first rising edge with rst_n=1.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).
- IDLE:
  - bit_valid && start: capture D as bit 0, count=1, go to SHIFT.
  - bit_valid without start is ignored.
  - WIDTH=1 special case: a start bit completes the word immediately.
- SHIFT:
  - Each bit_valid edge captures D at position count, then count+1.
  - bit_valid=0 holds all state; there is no timeout.
  - bit_valid && start mid-frame: discard the partial word, capture D as the new bit 0, count=1, stay in SHIFT.
  - Capture of bit WIDTH-1 completes the word and returns the FSM to IDLE (or goes to PARITY when enabled).
- Word completion, output buffer (evaluated on the completing edge):
  - Buffer empty, or data_valid && data_ready that same cycle: load data_out, data_valid=1 after the edge.
  - Latency: data_valid rises on the edge that samples the last bit, so it is visible one clk after that bit is presented.
  - Buffer full and data_ready=0: new word dropped, data_out unchanged, overrun=1 for exactly one cycle.
  - data_valid && data_ready with no completion: data_valid=0 next cycle; data_out keeps its old value.
- A start arriving in the same cycle a word completes cannot happen: completion consumes that bit.
- busy=1 in SHIFT/PARITY, else 0.
- Count width is clog2(WIDTH+1); it never wraps past WIDTH, it resets at completion.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - After bit WIDTH-1 the FSM enters PARITY and the next bit_valid bit is an even-parity bit (XOR of data bits ^ parity bit must be 0).
  - Word delivery and the overrun check happen on the parity edge.
  - Adds output parity_err (1 bit): one-cycle pulse on the parity edge when the check fails; the word is still delivered.
  - start in PARITY restarts the frame as in SHIFT.
- Undefined:
  - No PARITY state and no parity_err port.
  - Completion occurs on bit WIDTH-1.

Test Plan:
- Reset: rst_n=0 mid-frame after 3 bits -> data_valid=0, busy=0, data_out=0 immediately, without waiting for a clk edge. Then a full frame of 0xA5 -> data_out=8'hA5 delivered correctly.
- LSB-first frame: bits 1,0,1,0,0,1,0,1 with start on the first bit, data_ready=1 -> data_out=8'hA5, data_valid=1 for one cycle.
- Back-pressure: data_ready=0, send 0x3C then 0xFF -> data_out stays 8'h3C and overrun pulses once on the 0xFF completion edge. Raise data_ready -> data_valid falls next cycle.
- Simultaneous accept and complete: data_valid=1 with 0x11; data_ready=1 on the 0x22 completion edge -> data_out=8'h22, data_valid stays 1, overrun=0.
- Restart and gaps: 4 bits, then start with 8 bits of 0x0F, bit_valid toggled low between bits -> data_out=8'h0F, partial discarded. MSB_FIRST=1 with the same bits -> 8'hF0.
- Parity (macro defined): 0x07 followed by parity bit 1 -> parity_err=0. Followed by parity bit 0 -> parity_err pulses, data_out=8'h07.
